// File: rtl/line_scanout_if.sv
// Line buffer read/clear port plus the registered pixel stream toward the palette.
interface line_scanout_if;
   logic [9:0] l_addr;
   logic       l_re;
   logic       l_we;
   logic [7:0] l_wdata;
   logic [7:0] l_rdata;
   logic [7:0] pix;
   logic       pix_valid;

   modport master (
      output l_addr, l_re, l_we, l_wdata, pix, pix_valid,
      input  l_rdata
   );

   modport slave (
      input  l_addr, l_re, l_we, l_wdata, pix, pix_valid,
      output l_rdata
   );
endinterface

// File: rtl/line_scanout.sv
// Streams one sprite line-buffer bank as pixel-doubled colours, clearing entries on the second scan.
//
// state    | meaning
// S_IDLE   | between lines, waiting for h_start
// S_ACTIVE | phase 0 reads entry x, phase 1 clears it (if clr) and captures the colour
module line_scanout #(
   parameter int H_PIXELS = 320
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [8:0]     line_n,
   input  logic           h_start,
   input  logic [7:0]     bg_color,
   line_scanout_if.master bus
);

   localparam logic [8:0] X_LAST = 9'(H_PIXELS - 1);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t     state_q, state_d;
   logic [8:0] x_q, x_d;
   logic       phase_q, phase_d;
   logic       bank_q, bank_d;
   logic       clr_q, clr_d;
   logic       start;
   logic       capture;
   logic       re_c, we_c;
   logic [7:0] pix_q;
   logic       pv_q;
   logic       pv_age_q;

   logic       unused_line_bits;
   assign unused_line_bits = ^line_n[8:2];

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      phase_d = phase_q;
      bank_d  = bank_q;
      clr_d   = clr_q;
      start   = 1'b0;
      capture = 1'b0;
      re_c    = 1'b0;
      we_c    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (h_start) start = 1'b1;
         end
         S_ACTIVE: begin
            if (!phase_q) begin
               re_c    = 1'b1;
               phase_d = 1'b1;
            end else begin
               we_c    = clr_q;
               capture = 1'b1;
               if (x_q == X_LAST) begin
                  // the final edge is the only point where a new line may chain on
                  state_d = S_IDLE;
                  phase_d = 1'b0;
                  if (h_start) start = 1'b1;
               end else begin
                  x_d     = x_q + 9'd1;
                  phase_d = 1'b0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (start) begin
         state_d = S_ACTIVE;
         x_d     = '0;
         phase_d = 1'b0;
         bank_d  = line_n[1];
         clr_d   = line_n[0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         x_q      <= '0;
         phase_q  <= 1'b0;
         bank_q   <= 1'b0;
         clr_q    <= 1'b0;
         pix_q    <= '0;
         pv_q     <= 1'b0;
         pv_age_q <= 1'b1;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         phase_q <= phase_d;
         bank_q  <= bank_d;
         clr_q   <= clr_d;
         // each pixel is shown for two clocks; valid drops once that window lapses
         if (capture) begin
            pix_q    <= (bus.l_rdata == 8'h00) ? bg_color : bus.l_rdata;
            pv_q     <= 1'b1;
            pv_age_q <= 1'b0;
         end else if (!pv_age_q) begin
            pv_age_q <= 1'b1;
         end else begin
            pv_q <= 1'b0;
         end
      end
   end

   assign bus.l_addr    = {bank_q, x_q};
   assign bus.l_re      = re_c;
   assign bus.l_we      = we_c;
   assign bus.l_wdata   = 8'h00;
   assign bus.pix       = pix_q;
   assign bus.pix_valid = pv_q;

endmodule

// File: doc/line_scanout.md
# line_scanout

Reads the double-buffered sprite line buffer that the sprite DMA fills and streams it to the video output as pixel-doubled colour bytes. On the second scan of each rendered line it clears every entry it reads back to 0, so the DMA always writes into a transparent bank. It sits between the 1024×8 line buffer RAM (read/clear port) and the video DAC/palette stage. It is timed from the same `line_n` counter and `h_start` strobe as the video timing generator.

## Interface
- `H_PIXELS`, default 320: rendered pixels per line, range 1–512; each one is displayed for 2 clocks.
- `clk` in 1: pixel clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `line_n` in 9: current display line; `line_n[1]` is the bank being displayed, `line_n[0]` high = second scan of the rendered line.
- `h_start` in 1: one-cycle strobe; the first active pixel begins 2 clocks after the edge that samples it.
- `bg_color` in 8: colour substituted for transparent (0x00) entries.
- `l_addr` out 10: line buffer address `{bank, x[8:0]}`.
- `l_re` out 1: read enable; the RAM registers read data only when it is high.
- `l_we` out 1: clear write strobe; written data is always 0x00.
- `l_wdata` out 8: constant 0x00.
- `l_rdata` in 8: synchronous read data, valid the cycle after an `l_re` edge.
- `pix` out 8: registered output colour.
- `pix_valid` out 1: high while `pix` carries an active pixel.

## Operation
- **States:** IDLE and ACTIVE. ACTIVE holds a 9-bit `x` counter and a 1-bit `phase`.
- **IDLE → ACTIVE:** on an edge with `h_start` = 1.
  - Latch `bank` = `line_n[1]` and `clr` = `line_n[0]`.
  - Set `x` = 0 and `phase` = 0.
  - Later changes to `line_n` within the line have no effect.
- **ACTIVE, phase 0:**
  - `l_addr` = `{bank, x}`, `l_re` = 1, `l_we` = 0.
  - Next edge: `phase` becomes 1.
- **ACTIVE, phase 1:**
  - `l_addr` is unchanged, `l_re` = 0, `l_we` = `clr`.
  - Next edge: capture `pix` = (`l_rdata` == 0) ? `bg_color` : `l_rdata`, and set `pix_valid` = 1.
  - If `x` == `H_PIXELS`−1, go to IDLE; otherwise `x`+1 and `phase` 0.
- **Re-trigger:** `h_start` while ACTIVE is ignored. The exception is the final phase-1 edge: `h_start` there is accepted and the next line starts back-to-back with no gap.
- **IDLE outputs:** `l_re` = 0, `l_we` = 0, `l_addr` holds its last value.
- **pix_valid fall:** `pix_valid` clears on the first edge after the final pixel has been held for 2 clocks. During back-to-back lines it stays high continuously.
- **Bank ownership:** the clear port touches only the displayed bank (`line_n[1]`). The DMA writes only bank `~line_n[1]`, so the two never access the same bank.
- **Width rules:**
  - `x` is 9 bits and never exceeds `H_PIXELS`−1, so there is no wrap.
  - `l_addr[9]` = latched `bank`.

## Timing
- **Reset values:** `l_addr` = 0, `l_re` = 0, `l_we` = 0, `l_wdata` = 0, `pix` = 0, `pix_valid` = 0, state IDLE. Reset asserted mid-line aborts the line immediately, with no further clears.
- **Latency:** with `h_start` sampled at edge E0:
  - Address 0 is presented E0→E1.
  - Data is read at E1.
  - `pix` for x = 0 is valid from E2.
  - `pix` for x = n is valid over E(2+2n) to E(4+2n).
- **Active line span:**
  - `pix_valid` is high from E2 until it falls at E(2+2·`H_PIXELS`).
  - The last clear write occurs at edge E(2·`H_PIXELS`).
- **Write/read separation:** every clear write follows its read by exactly one cycle at the same address. `l_re` is never high in the same cycle as `l_we`.

## Test plan
- **Reset mid-line:** assert `rst` at pixel 10 → all outputs 0 within the same cycle; entries 10..319 remain uncleared.
- **Basic read:** bank 0 filled with x&0xFF, `line_n` = 4, `h_start` pulse → `pix` sequence 0,0,1,1,…,0x3F,0x3F from E2; `pix_valid` high for 640 clocks; `l_we` never asserts; RAM unchanged.
- **Clear pass:** same data, `line_n` = 5 → identical `pix` stream; afterwards all 320 entries of bank 0 read 0x00; bank 1 untouched.
- **Transparency:** entry 7 = 0x00, `bg_color` = 0xA5 → pixel 7 shows 0xA5 for 2 clocks; neighbouring pixels are unaffected.
- **Line boundary and `line_n` change:** `line_n` changes from 6 to 7 mid-line → bank and `clr` stay latched for that line. Separately, `h_start` on the final phase-1 edge → the next line starts at x = 0 with `pix_valid` never dropping.
- **Re-trigger and width edge case:** `h_start` at x = 100 → ignored, with no restart and no extra clear. Separately, `H_PIXELS` = 512 → `l_addr` reaches `{bank, 0x1FF}` without wrap.
